// File: rtl/fifo_fm0_tx_if.sv
// rtl/fifo_fm0_tx_if.sv - upstream byte FIFO read port for the FM0 transmitter
// master = transmitter pulling bytes, slave = FIFO supplying them.
interface fifo_fm0_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read
    );
endinterface

// File: rtl/fifo_fm0_tx.sv
// rtl/fifo_fm0_tx.sv - FM0 line encoder that streams bytes MSB-first from an upstream FIFO
// Back-to-back bytes are sustained by prefetching the next byte during the last bit of the current one.
module fifo_fm0_tx #(
    parameter int unsigned HALF_BIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          start,
    fifo_fm0_tx_if.master fifo,
    output logic          tx_out,
    output logic          busy,
    output logic          done
);

    localparam int unsigned   CW   = $clog2(2 * HALF_BIT);
    localparam logic [CW-1:0] MID  = CW'(HALF_BIT);
    localparam logic [CW-1:0] LAST = CW'(2 * HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        DUMMY,
        FINISH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [7:0]    hold;
    logic          rd_q;
    logic          done_q;
    logic          tx_q;
    logic          busy_q;
    logic          pf_req;
    logic          pf_due;
    logic          pf_full;
    logic          pf_late;
    logic          bit_end;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            hold    <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            pf_req  <= 1'b0;
            pf_due  <= 1'b0;
            pf_full <= 1'b0;
            pf_late <= 1'b0;
        end else if (en) begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            // A prefetch pop on the previous enabled edge means fifo_data is valid now.
            pf_due <= rd_q && (state == SEND);
            if (pf_due) begin
                if (pf_late) begin
                    shift   <= fifo.fifo_data;
                    pf_late <= 1'b0;
                    pf_req  <= 1'b0;
                end else begin
                    hold    <= fifo.fifo_data;
                    pf_full <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    tx_q <= 1'b0;
                    if (start && !fifo.fifo_empty) begin
                        state  <= FETCH;
                        rd_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end

                FETCH: begin
                    state <= LOAD;
                end

                LOAD: begin
                    shift <= fifo.fifo_data;
                    idx   <= 3'd7;
                    cnt   <= '0;
                    state <= SEND;
                end

                SEND: begin
                    if (cnt == '0) begin
                        tx_q <= ~tx_q;
                    end else if (cnt == MID && !shift[idx]) begin
                        tx_q <= ~tx_q;
                    end
                    if (idx == 3'd0 && cnt == MID && !fifo.fifo_empty && !pf_req) begin
                        rd_q   <= 1'b1;
                        pf_req <= 1'b1;
                    end
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx != 3'd0) begin
                            idx <= idx - 3'd1;
                        end else if (pf_req) begin
                            // Next byte starts with no gap; for short half-bits its data may still be in flight.
                            idx     <= 3'd7;
                            pf_full <= 1'b0;
                            pf_req  <= 1'b0;
                            if (pf_full) begin
                                shift <= hold;
                            end else if (pf_due) begin
                                shift <= fifo.fifo_data;
                            end else begin
                                pf_late <= 1'b1;
                                pf_req  <= 1'b1;
                            end
                        end else begin
                            state <= DUMMY;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DUMMY: begin
                    if (cnt == '0) begin
                        tx_q <= ~tx_q;
                    end
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FINISH: begin
                    tx_q    <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pf_req  <= 1'b0;
                    pf_full <= 1'b0;
                    pf_late <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes are held while disabled and only reach the pins once en returns.
    assign fifo.fifo_read = rd_q & en;
    assign done           = done_q & en;
    assign tx_out         = tx_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_fifo_fm0_tx.sv
// tb/tb_fifo_fm0_tx.sv - scoreboard bench for fifo_fm0_tx with an FM0 waveform reference model
module tb_fifo_fm0_tx;

    localparam int HB = 4;

    typedef struct {
        int len;
        int reads;
        int nbits;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic start;
    logic tx_out;
    logic busy;
    logic done;

    logic       f_empty = 1'b1;
    logic [7:0] f_data  = 8'h00;
    logic [7:0] fq[$];
    logic [7:0] fb[$];

    frame_t sb[$];
    bit     exp_bits[$];
    bit     act[$];

    int   tests = 0;
    int   fails = 0;
    int   frames_done = 0;
    bit   in_frame = 1'b0;
    int   nsamp;
    int   nread;
    int   bad;
    logic last_tx;
    logic en_q = 1'b1;

    fifo_fm0_tx_if fif ();

    assign fif.fifo_empty = f_empty;
    assign fif.fifo_data  = f_data;

    fifo_fm0_tx #(.HALF_BIT(HB)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .start  (start),
        .fifo   (fif),
        .tx_out (tx_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Upstream FIFO: data registered on a pop, empty flag tracks occupancy after the pop.
    always @(posedge clk) begin
        if (fif.fifo_read && fq.size() > 0) begin
            f_data <= fq.pop_front();
        end
        f_empty <= (fq.size() == 0);
    end

    always @(posedge clk) en_q <= en;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    // Line levels one sample per enabled cycle from the start edge through the done cycle.
    task automatic push_expect(input int stall_len);
        frame_t f;
        bit     lvl;
        int     n0;
        n0  = exp_bits.size();
        lvl = 1'b0;
        repeat (3) exp_bits.push_back(1'b0);
        foreach (fb[i]) begin
            for (int b = 7; b >= 0; b--) begin
                lvl = ~lvl;
                repeat (HB) exp_bits.push_back(lvl);
                if (fb[i][b] == 1'b0) lvl = ~lvl;
                repeat (HB) exp_bits.push_back(lvl);
            end
        end
        lvl = ~lvl;
        repeat (2 * HB) exp_bits.push_back(lvl);
        exp_bits.push_back(1'b0);
        f.len   = fb.size() * 16 * HB + 2 * HB + 3 + stall_len;
        f.reads = fb.size();
        f.nbits = exp_bits.size() - n0;
        sb.push_back(f);
    endtask

    task automatic finish_frame();
        frame_t f;
        int     mism;
        bit     b;
        check("frame_queued", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            f    = sb.pop_front();
            mism = (act.size() != f.nbits) ? 1 : 0;
            for (int i = 0; i < f.nbits; i++) begin
                b = exp_bits.pop_front();
                if (i < act.size() && act[i] !== b) mism++;
            end
            check("frame_len", nsamp - 1, f.len);
            check("frame_reads", nread, f.reads);
            check("frame_wave", mism, 0);
            check("frame_busy_freeze", bad, 0);
        end
        frames_done++;
    endtask

    always @(negedge clk) begin
        if (fif.fifo_read) check("read_nonempty", f_empty, 0);
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && busy) begin
                in_frame = 1'b1;
                act.delete();
                nsamp   = 0;
                nread   = 0;
                bad     = 0;
                last_tx = tx_out;
            end
            if (in_frame) begin
                nsamp++;
                if (fif.fifo_read) nread++;
                if (en_q) act.push_back(tx_out);
                else if (tx_out !== last_tx) bad++;
                last_tx = tx_out;
                if (done) begin
                    finish_frame();
                    in_frame = 1'b0;
                end else if (!busy) begin
                    bad++;
                end
            end else begin
                check("idle_done", done, 0);
                check("idle_read", fif.fifo_read, 0);
            end
        end
    end

    task automatic run_frame(input int stall_off, input int stall_len, input bit restart);
        int target;
        foreach (fb[i]) fq.push_back(fb[i]);
        @(posedge clk); #2;
        push_expect(stall_len);
        target = frames_done + 1;
        start  = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
        for (int c = 1; c < 2000 && frames_done < target; c++) begin
            if (stall_len > 0 && c == stall_off) en = 1'b0;
            if (stall_len > 0 && c == stall_off + stall_len) en = 1'b1;
            if (restart && c == 30) start = 1'b1;
            if (restart && c == 33) start = 1'b0;
            @(posedge clk); #2;
        end
        en    = 1'b1;
        start = 1'b0;
        check("frame_timeout", frames_done >= target, 1);
        repeat (3) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        int n;
        int soff;
        int slen;
        int idle_bad;
        reset = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_tx", tx_out, 0);
        check("reset_busy", busy, 0);
        check("reset_read", fif.fifo_read, 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #2;
        end

        fb = '{8'hA5};
        run_frame(0, 0, 1'b0);
        fb = '{8'h00, 8'hFF};
        run_frame(0, 0, 1'b0);

        idle_bad = 0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy !== 1'b0 || tx_out !== 1'b0 || fif.fifo_read !== 1'b0) idle_bad++;
            @(posedge clk); #2;
        end
        check("empty_start", idle_bad, 0);

        fb = '{8'hA5};
        run_frame(21, 10, 1'b0);
        fb = '{8'h3C};
        run_frame(0, 0, 1'b1);

        fb = '{8'hC3, 8'h5A};
        foreach (fb[i]) fq.push_back(fb[i]);
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (37) begin
            @(posedge clk); #2;
        end
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk); #2;
        check("abort_tx", tx_out, 0);
        check("abort_busy", busy, 0);
        check("abort_read", fif.fifo_read, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        fq.delete();
        repeat (5) begin
            @(posedge clk); #2;
        end
        fb = '{8'h81};
        run_frame(0, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            fb.delete();
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            soff = $urandom_range(1, 60);
            slen = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
            run_frame(soff, slen, 1'($urandom_range(0, 1)));
        end

        check("pending_frames", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d frames completed", frames_done);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_fm0_tx.md
FIFO_FM0_TX -- requirements
Module: fifo_fm0_tx

Interface
REQ-001 SHALL have parameter HALF_BIT, default 4: clk cycles per FM0 half-bit; legal range 2..255.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  block enable; low freezes all state.
REQ-005 SHALL have port start  input  1  frame request, sampled in IDLE only.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  8  FIFO read data, valid the cycle after fifo_read.
REQ-008 SHALL have port fifo_read  output  1  one-cycle FIFO pop strobe.
REQ-009 SHALL have port tx_out  output  1  registered FM0 line level.
REQ-010 SHALL have port busy  output  1  high from FETCH entry until return to IDLE.
REQ-011 SHALL have port done  output  1  one-cycle end-of-frame pulse.

Function
REQ-012 SHALL implement states IDLE, FETCH, LOAD, SEND, DUMMY, FINISH.
REQ-013 IDLE: tx_out=0, busy=0; start=1 and en=1 and fifo_empty=0 -> FETCH; otherwise remain (start with empty FIFO ignored).
REQ-014 FETCH: fifo_read=1 for exactly one cycle -> LOAD.
REQ-015 LOAD: capture fifo_data into shift register, bit index 7 -> SEND.
REQ-016 Latency: first tx_out transition on the 3rd rising edge after the edge sampling start.
REQ-017 SEND: bits MSB-first, each 2*HALF_BIT cycles; tx_out inverts at every bit start.
REQ-018 SEND: at mid-bit (HALF_BIT cycles after bit start) tx_out inverts again if bit=0, holds if bit=1.
REQ-019 Prefetch: on the first cycle of the second half of bit index 0, if fifo_empty=0, pulse fifo_read once and capture fifo_data next cycle into a holding register.
REQ-020 At end of bit index 0: if prefetched, load holding register, bit index 7, stay in SEND with no gap; else -> DUMMY.
REQ-021 DUMMY: one FM0 data-1 (inversion at start, none at mid) lasting 2*HALF_BIT cycles -> FINISH.
REQ-022 FINISH: tx_out=0, done=1 for one cycle -> IDLE.
REQ-023 fifo_read SHALL never assert while fifo_empty=1 and at most once per byte.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 en=0 in any state SHALL hold state, counters, shift/holding registers and tx_out; fifo_read and done forced 0; a pending strobe issues after en returns.
REQ-026 Frame duration SHALL be N*16*HALF_BIT + 2*HALF_BIT + 3 cycles for N bytes with en held high (start edge to done).

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, tx_out=0, fifo_read=0, busy=0, done=0, counters and registers 0, regardless of en or state.
REQ-028 Reset mid-frame SHALL abort without done pulse and without further fifo_read; an already-issued pop is discarded.

Verification
REQ-029 HALF_BIT=4, FIFO holds 0xA5, start -> one fifo_read, tx_out 0->1 at edge 3, bit toggle pattern 1,0,1,0,0,1,0,1 encoded, dummy 1, done after 8*8+8+3=75 cycles, tx_out=0.
REQ-030 FIFO holds 0x00,0xFF -> exactly 2 fifo_read pulses, no idle gap between bytes, 16 transitions for 0x00 then 8 for 0xFF, then dummy.
REQ-031 start with fifo_empty=1 -> no fifo_read, busy stays 0, tx_out stays 0.
REQ-032 reset pulsed during bit 3 of first byte -> next edge all outputs 0, no done, subsequent start sends a fresh frame.
REQ-033 en=0 for 10 cycles mid-bit -> tx_out frozen, frame length extended by exactly 10 cycles, waveform otherwise identical.
REQ-034 start re-asserted during SEND -> no effect; single done at frame end.
